dbus_arbiter_ic: RTL and testbench

DBUS_ARBITER_IC -- requirements
Module: dbus_arbiter_ic

---
 rtl/dbus_arbiter_ic.sv | 201 ++++++++++++++++++++
 tb/tb_dbus_arbiter_ic.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter_ic.sv
// Round-robin D-bus arbiter/interconnect: N masters share one transaction path to N address-decoded slaves.
// Optional DBUS_IC_TIMEOUT_EN adds a stall watchdog that error-completes a transaction if the selected slave never acks.
module dbus_arbiter_ic #(
  parameter int N_MASTERS      = 2,
  parameter int N_SLAVES       = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTERS-1:0]       m_req,
  input  logic [N_MASTERS-1:0]       m_we,
  input  logic [N_MASTERS*32-1:0]    m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [N_MASTERS-1:0]       m_ack,
  output logic [N_MASTERS-1:0]       m_err,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  // Handshake: a master raises m_req and holds it with stable payload until m_ack;
  // m_ack is a one-cycle pulse, m_err and m_rdata are meaningful only while m_ack is high.
  localparam int MI_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SI_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [MI_W-1:0]     last_q, grant_q;
  logic                we_q, err_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [SI_W-1:0]     sel_q;

  logic [MI_W-1:0]     pick, pick_hi, pick_lo;
  logic                hi_vld, lo_vld;
  logic                pick_we;
  logic [31:0]         pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [STRB_W-1:0]   pick_wstrb;
  logic [SI_W-1:0]     dec_idx;
  logic                dec_hit;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_hit;

  // Round robin: lowest requester above last grant, else lowest requester overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        pick_lo = MI_W'(i);
        lo_vld  = 1'b1;
        if (i > int'(last_q)) begin
          pick_hi = MI_W'(i);
          hi_vld  = 1'b1;
        end
      end
    end
    pick = hi_vld ? pick_hi : pick_lo;
  end

  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_wstrb = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (pick == MI_W'(i)) begin
        pick_we    = m_we[i];
        pick_addr  = m_addr[i*32 +: 32];
        pick_wdata = m_wdata[i*DATA_W +: DATA_W];
        pick_wstrb = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Descending scan so the lowest-index hit is the one that sticks.
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((pick_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        dec_idx = SI_W'(i);
        dec_hit = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SI_W'(i)) begin
        sel_ack   = s_ack[i];
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef DBUS_IC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_q == ADDR) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state_q == ADDR) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lo_vld) state_d = dec_hit ? ADDR : RESP;
      ADDR: if (sel_ack || tmo_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= MI_W'(N_MASTERS - 1);
      grant_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && lo_vld) begin
        grant_q <= pick;
        last_q  <= pick;
        we_q    <= pick_we;
        addr_q  <= pick_addr;
        wdata_q <= pick_wdata;
        wstrb_q <= pick_wstrb;
        sel_q   <= dec_idx;
        err_q   <= ~dec_hit;
      end else if (state_q == ADDR) begin
        if (sel_ack) begin
          rdata_q <= sel_rdata;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      s_sel[i] = (state_q == ADDR) && (sel_q == SI_W'(i));
    end
    m_ack = '0;
    m_err = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ack[i] = (state_q == RESP) && (grant_q == MI_W'(i));
      m_err[i] = (state_q == RESP) && (grant_q == MI_W'(i)) && err_q;
    end
  end

  assign s_we      = (state_q == ADDR) && we_q;
  assign s_addr    = (state_q == ADDR) ? addr_q  : '0;
  assign s_wdata   = (state_q == ADDR) ? wdata_q : '0;
  assign s_wstrb   = (state_q == ADDR) ? wstrb_q : '0;
  assign m_rdata   = (state_q == RESP && !we_q && !err_q) ? rdata_q : '0;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dbus_arbiter_ic.sv
// Directed bench for dbus_arbiter_ic: 2 masters, 4 slaves with one overlapping decode window.
// Inputs change #1 after the rising edge; outputs are checked at that same point.
module tb_dbus_arbiter_ic;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   m_req, m_we;
  logic [63:0]  m_addr, m_wdata;
  logic [7:0]   m_wstrb;
  logic [1:0]   m_ack, m_err;
  logic [31:0]  m_rdata;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ack;
  logic [127:0] s_rdata;
  logic         busy;
  logic [1:0]   dbg_state;
  logic [3:0]   ack_en, ack_force;

  int checks = 0;
  int errors = 0;

  // slave0 0x2xxx_xxxx, slave1 0x1xxx_xxxx, slave2 0x0200_xxxx, slave3 0x2/0x3xxx_xxxx (overlaps slave0)
  dbus_arbiter_ic #(
    .N_MASTERS(2), .N_SLAVES(4), .DATA_W(32), .TIMEOUT_CYCLES(16),
    .SLAVE_BASE({32'h2000_0000, 32'h0200_0000, 32'h1000_0000, 32'h2000_0000}),
    .SLAVE_MASK({32'hE000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000})
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ack(m_ack), .m_err(m_err),
    .m_rdata(m_rdata), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ack(s_ack), .s_rdata(s_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign s_rdata = {32'hA5A5_5A5A, 32'h0123_4567, 32'hCAFE_F00D, 32'hDEAD_BEEF};
  assign s_ack   = (s_sel & ack_en) | ack_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    ack_en = 4'hF; ack_force = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_ack", m_ack, 2'b00);
    chk("rst_s_sel", s_sel, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    rst = 1'b0;

    // Zero-wait read by master 0 from slave 0
    m_req = 2'b01; m_we = 2'b00; m_addr[31:0] = 32'h2000_0010;
    chk("rd_c0_busy", busy, 1'b0);
    tick();
    chk("rd_c1_sel", s_sel, 4'b0001);
    chk("rd_c1_addr", s_addr, 32'h2000_0010);
    chk("rd_c1_we", s_we, 1'b0);
    chk("rd_c1_busy", busy, 1'b1);
    chk("rd_c1_ack", m_ack, 2'b00);
    tick();
    chk("rd_c2_ack", m_ack, 2'b01);
    chk("rd_c2_err", m_err, 2'b00);
    chk("rd_c2_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("rd_c2_sel", s_sel, 4'h0);
    m_req = 2'b00;
    tick();
    chk("rd_c3_ack", m_ack, 2'b00);
    chk("rd_c3_busy", busy, 1'b0);

    // 0x3000_0000 hits only slave3
    m_req = 2'b10; m_addr[63:32] = 32'h3000_0000;
    tick();
    chk("s3_sel", s_sel, 4'b1000);
    tick();
    chk("s3_ack", m_ack, 2'b10);
    chk("s3_rdata", m_rdata, 32'hA5A5_5A5A);
    m_req = 2'b00;
    tick();

    // Write by master 0; 0x2000_0040 hits slave0 and slave3, lowest wins
    m_req = 2'b01; m_we = 2'b01; m_addr[31:0] = 32'h2000_0040;
    m_wdata[31:0] = 32'h1234_5678; m_wstrb[3:0] = 4'h3;
    tick();
    chk("wr_sel", s_sel, 4'b0001);
    chk("wr_we", s_we, 1'b1);
    chk("wr_wdata", s_wdata, 32'h1234_5678);
    chk("wr_wstrb", s_wstrb, 4'h3);
    tick();
    chk("wr_ack", m_ack, 2'b01);
    chk("wr_rdata", m_rdata, 32'h0);
    chk("wr_err", m_err, 2'b00);
    m_req = 2'b00;
    tick();
    chk("wr_idle_wdata", s_wdata, 32'h0);

    // Decode miss
    m_addr[31:0] = 32'h9000_0000; m_req = 2'b01;
    tick();
    chk("miss_ack", m_ack, 2'b01);
    chk("miss_err", m_err, 2'b01);
    chk("miss_sel", s_sel, 4'h0);
    chk("miss_rdata", m_rdata, 32'h0);
    chk("miss_state", dbg_state, 2'd2);
    m_req = 2'b00;
    tick();
    chk("miss_after_ack", m_ack, 2'b00);
    chk("miss_after_busy", busy, 1'b0);

    // Both masters request continuously from reset: acks on cycles 2,5,8,11 for 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_we = 2'b00; m_addr = {32'h1000_0004, 32'h2000_0010}; m_req = 2'b11;
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 2) begin
        chk($sformatf("rr_ack_c%0d", c), m_ack, ((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
        chk($sformatf("rr_rdata_c%0d", c), m_rdata,
            ((c / 3) % 2 == 1) ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
      end else begin
        chk($sformatf("rr_ack_c%0d", c), m_ack, 2'b00);
      end
      tick();
    end
    m_req = 2'b00;
    tick();

    // Stalled slave; acks from non-selected slaves must not complete it
    ack_en = 4'h0; ack_force = 4'b1110; m_req = 2'b01;
    tick();
    chk("stall_sel", s_sel, 4'b0001);
`ifdef DBUS_IC_TIMEOUT_EN
    repeat (15) tick();
    chk("tmo_c16_ack", m_ack, 2'b00);
    chk("tmo_c16_busy", busy, 1'b1);
    tick();
    chk("tmo_c17_ack", m_ack, 2'b01);
    chk("tmo_c17_err", m_err, 2'b01);
    chk("tmo_c17_rdata", m_rdata, 32'h0);
    m_req = 2'b00; ack_force = 4'hF;
    tick();
    chk("tmo_late_ack", m_ack, 2'b00);
    tick();
    chk("tmo_late_ack2", m_ack, 2'b00);
    chk("tmo_late_busy", busy, 1'b0);
    ack_force = 4'h0; ack_en = 4'hF;
`else
    repeat (39) tick();
    chk("wait_ack", m_ack, 2'b00);
    chk("wait_busy", busy, 1'b1);
    chk("wait_sel", s_sel, 4'b0001);
    ack_force = 4'h0; ack_en = 4'hF;
    tick();
    chk("wait_done_ack", m_ack, 2'b01);
    chk("wait_done_err", m_err, 2'b00);
    chk("wait_done_rdata", m_rdata, 32'hDEAD_BEEF);
    m_req = 2'b00;
    tick();
`endif

    // Reset during an ADDR wait, then master 0 must win first
    ack_en = 4'h0; m_req = 2'b10;
    tick();
    chk("abort_sel_before", s_sel, 4'b0010);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_sel", s_sel, 4'h0);
    chk("abort_ack", m_ack, 2'b00);
    chk("abort_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("abort_ack2", m_ack, 2'b00);
    rst = 1'b0; m_req = 2'b11; ack_en = 4'hF;
    tick();
    chk("post_rst_sel", s_sel, 4'b0001);
    tick();
    chk("post_rst_ack", m_ack, 2'b01);
    m_req = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
